// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - shared types, latency constants and helpers for the dual-port on-chip RAM
package onchip_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int LAT_UNREG = 1;
    localparam int LAT_REG   = 2;

    function automatic int clog2(input longint value);
        int result;
        result = 0;
        while ((64'(1) << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/onchip_ram_tdp_core.sv
// rtl/onchip_ram_tdp_core.sv - inferred true-dual-port RAM with byte enables and optional output register
module onchip_ram_tdp_core
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int BE_W         = DATA_W / 8,
    parameter int DEPTH        = 97500,
    parameter int IDX_W        = 17,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              a_we,
    input  logic [IDX_W-1:0]  a_addr,
    input  logic [BE_W-1:0]   a_be,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_q,
    input  logic              b_we,
    input  logic [IDX_W-1:0]  b_addr,
    input  logic [BE_W-1:0]   b_be,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_q
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_ram_q;
    logic [DATA_W-1:0] b_ram_q;

    // Reads sample the pre-edge contents, so a cross-port read of a word being written returns old data.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (a_we && a_be[i]) begin
                    mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
                if (b_we && b_be[i]) begin
                    mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
                end
            end
            a_ram_q <= mem[a_addr];
            b_ram_q <= mem[b_addr];
        end
    end

    generate
        if (READ_LATENCY == LAT_REG) begin : g_out_reg
            logic [DATA_W-1:0] a_q_r;
            logic [DATA_W-1:0] b_q_r;
            always_ff @(posedge clk) begin
                if (en) begin
                    a_q_r <= a_ram_q;
                    b_q_r <= b_ram_q;
                end
            end
            assign a_q = a_q_r;
            assign b_q = b_q_r;
        end else begin : g_no_out_reg
            assign a_q = a_ram_q;
            assign b_q = b_ram_q;
        end
    endgenerate

endmodule

// File: rtl/onchip_ram_avmm_dp.sv
// rtl/onchip_ram_avmm_dp.sv - dual Avalon-MM slave on-chip RAM with zero-clear sequencer and collision policy
module onchip_ram_avmm_dp
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BE_W           = DATA_W / 8,
    parameter int DEPTH          = 97500,
    parameter int ADDR_W         = 17,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic              s1_waitrequest,
    input  logic [ADDR_W-1:0] s2_address,
    input  logic              s2_chipselect,
    input  logic              s2_read,
    input  logic              s2_write,
    input  logic [BE_W-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0] s2_writedata,
    output logic [DATA_W-1:0] s2_readdata,
    output logic              s2_readdatavalid,
    output logic              s2_waitrequest,
    output logic              init_busy
);

    localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    generate
        if (DATA_W % 8 != 0) begin : g_chk_data_w
            $error("DATA_W must be a multiple of 8");
        end
        if (BE_W != DATA_W / 8) begin : g_chk_be_w
            $error("BE_W must equal DATA_W/8");
        end
        if (READ_LATENCY != LAT_UNREG && READ_LATENCY != LAT_REG) begin : g_chk_lat
            $error("READ_LATENCY must be 1 or 2");
        end
        if (clog2(DEPTH) > ADDR_W) begin : g_chk_addr_w
            $error("ADDR_W too narrow for DEPTH");
        end
    endgenerate

    logic en;
    assign en = clken & ~reset_req;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q <= '0;
        end else if (en) begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    logic clearing;
    assign clearing  = (state_q == ST_CLEAR);
    assign init_busy = clearing;

    assign s1_waitrequest = reset | clearing | ~en;
    assign s2_waitrequest = reset | clearing | ~en;

    logic s1_acc, s1_rd_acc, s1_in_range, s1_we;
    logic s2_acc, s2_rd_acc, s2_in_range, s2_we;

    // A simultaneous read+write is treated as a write only.
    assign s1_acc      = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
    assign s1_rd_acc   = s1_acc & ~s1_write;
    assign s1_in_range = (s1_address <= LAST_ADDR);
    assign s1_we       = s1_acc & s1_write & s1_in_range;

    assign s2_acc      = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
    assign s2_rd_acc   = s2_acc & ~s2_write;
    assign s2_in_range = (s2_address <= LAST_ADDR);
    assign s2_we       = s2_acc & s2_write & s2_in_range;

    logic              ram_a_we, ram_b_we;
    logic [IDX_W-1:0]  ram_a_addr, ram_b_addr;
    logic [BE_W-1:0]   ram_a_be, ram_b_be;
    logic [DATA_W-1:0] ram_a_wdata, ram_a_q, ram_b_q;

    // Port A doubles as the zero-fill write path while the clear sequencer runs.
    assign ram_a_we    = clearing | s1_we;
    assign ram_a_addr  = clearing ? clr_cnt_q[IDX_W-1:0]
                       : (s1_in_range ? s1_address[IDX_W-1:0] : '0);
    assign ram_a_be    = clearing ? '1 : s1_byteenable;
    assign ram_a_wdata = clearing ? '0 : s1_writedata;

    // On a same-word double write, s1 owns every byte it enables; s2 keeps only the remainder.
    assign ram_b_we   = s2_we;
    assign ram_b_addr = s2_in_range ? s2_address[IDX_W-1:0] : '0;
    assign ram_b_be   = s2_byteenable
                      & ~((ram_a_we && ram_b_we && ram_a_addr == ram_b_addr) ? ram_a_be : '0);

    onchip_ram_tdp_core #(
        .DATA_W       (DATA_W),
        .BE_W         (BE_W),
        .DEPTH        (DEPTH),
        .IDX_W        (IDX_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_core (
        .clk     (clk),
        .en      (en),
        .a_we    (ram_a_we),
        .a_addr  (ram_a_addr),
        .a_be    (ram_a_be),
        .a_wdata (ram_a_wdata),
        .a_q     (ram_a_q),
        .b_we    (ram_b_we),
        .b_addr  (ram_b_addr),
        .b_be    (ram_b_be),
        .b_wdata (s2_writedata),
        .b_q     (ram_b_q)
    );

    logic [READ_LATENCY-1:0] s1_vld_q, s1_oor_q, s2_vld_q, s2_oor_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q <= '0;
            s1_oor_q <= '0;
            s2_vld_q <= '0;
            s2_oor_q <= '0;
        end else if (en) begin
            s1_vld_q <= (s1_vld_q << 1) | READ_LATENCY'(s1_rd_acc);
            s1_oor_q <= (s1_oor_q << 1) | READ_LATENCY'(s1_rd_acc & ~s1_in_range);
            s2_vld_q <= (s2_vld_q << 1) | READ_LATENCY'(s2_rd_acc);
            s2_oor_q <= (s2_oor_q << 1) | READ_LATENCY'(s2_rd_acc & ~s2_in_range);
        end
    end

    assign s1_readdatavalid = s1_vld_q[READ_LATENCY-1];
    assign s2_readdatavalid = s2_vld_q[READ_LATENCY-1];

    assign s1_readdata = (s1_vld_q[READ_LATENCY-1] & ~s1_oor_q[READ_LATENCY-1]) ? ram_a_q : '0;
    assign s2_readdata = (s2_vld_q[READ_LATENCY-1] & ~s2_oor_q[READ_LATENCY-1]) ? ram_b_q : '0;

endmodule

// File: tb/tb_onchip_ram_avmm_dp.sv
// tb/tb_onchip_ram_avmm_dp.sv - table-driven scoreboard bench for onchip_ram_avmm_dp
module tb_onchip_ram_avmm_dp;

    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int LAT   = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clken = 1'b1;
    logic          reset_req = 1'b0;
    logic [AW-1:0] s1_address = '0, s2_address = '0;
    logic          s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic          s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
    logic [BW-1:0] s1_byteenable = '0, s2_byteenable = '0;
    logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;
    logic [DW-1:0] s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s2_readdatavalid;
    logic          s1_waitrequest, s2_waitrequest;
    logic          init_busy;

    always #5 clk = ~clk;

    onchip_ram_avmm_dp #(
        .DATA_W         (DW),
        .DEPTH          (DEPTH),
        .ADDR_W         (AW),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clken            (clken),
        .reset_req        (reset_req),
        .s1_address       (s1_address),
        .s1_chipselect    (s1_chipselect),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_byteenable    (s1_byteenable),
        .s1_writedata     (s1_writedata),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s1_waitrequest   (s1_waitrequest),
        .s2_address       (s2_address),
        .s2_chipselect    (s2_chipselect),
        .s2_read          (s2_read),
        .s2_write         (s2_write),
        .s2_byteenable    (s2_byteenable),
        .s2_writedata     (s2_writedata),
        .s2_readdata      (s2_readdata),
        .s2_readdatavalid (s2_readdatavalid),
        .s2_waitrequest   (s2_waitrequest),
        .init_busy        (init_busy)
    );

    typedef struct {
        bit            r1, w1;
        logic [AW-1:0] a1;
        logic [BW-1:0] b1;
        logic [DW-1:0] d1, e1;
        bit            r2, w2;
        logic [AW-1:0] a2;
        logic [BW-1:0] b2;
        logic [DW-1:0] d2, e2;
        bit            en;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   ecnt = 0;
    bit   en_last = 1'b0;
    int   pulses2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input bit r1, input bit w1, input logic [AW-1:0] a1,
                                input logic [BW-1:0] b1, input logic [DW-1:0] d1, input logic [DW-1:0] e1,
                                input bit r2, input bit w2, input logic [AW-1:0] a2,
                                input logic [BW-1:0] b2, input logic [DW-1:0] d2, input logic [DW-1:0] e2,
                                input bit en);
        vec_t v;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.b1 = b1; v.d1 = d1; v.e1 = e1;
        v.r2 = r2; v.w2 = w2; v.a2 = a2; v.b2 = b2; v.d2 = d2; v.e2 = e2;
        v.en = en;
        return v;
    endfunction

    always @(posedge clk) begin
        en_last <= clken & ~reset_req & ~reset;
        if (clken && !reset_req && !reset) ecnt <= ecnt + 1;
        if (reset) begin
            q1.delete();
            q2.delete();
        end
    end

    // Only edges that were enabled can produce a fresh readdatavalid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (en_last) begin
            if (s1_readdatavalid) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL s1_unexpected_valid actual=1 required=0 data=%0h", s1_readdata);
                end else begin
                    e = q1.pop_front();
                    chk("s1_latency_cycle", 64'(ecnt), 64'(e.due));
                    chk("s1_readdata", 64'(s1_readdata), 64'(e.data));
                end
            end else if (q1.size() > 0 && q1[0].due <= ecnt) begin
                checks++; failures++;
                $display("FAIL s1_missing_valid actual=0 required=1 due=%0d", q1[0].due);
                void'(q1.pop_front());
            end
            if (s2_readdatavalid) begin
                pulses2++;
                if (q2.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL s2_unexpected_valid actual=1 required=0 data=%0h", s2_readdata);
                end else begin
                    e = q2.pop_front();
                    chk("s2_latency_cycle", 64'(ecnt), 64'(e.due));
                    chk("s2_readdata", 64'(s2_readdata), 64'(e.data));
                end
            end else if (q2.size() > 0 && q2[0].due <= ecnt) begin
                checks++; failures++;
                $display("FAIL s2_missing_valid actual=0 required=1 due=%0d", q2[0].due);
                void'(q2.pop_front());
            end
        end
    end

    task automatic set_idle();
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
        clken = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        #2;
        clken = v.en;
        s1_chipselect = v.r1 | v.w1; s1_read = v.r1; s1_write = v.w1;
        s1_address = v.a1; s1_byteenable = v.b1; s1_writedata = v.d1;
        s2_chipselect = v.r2 | v.w2; s2_read = v.r2; s2_write = v.w2;
        s2_address = v.a2; s2_byteenable = v.b2; s2_writedata = v.d2;
        #1;
        chk($sformatf("vec%0d_s1_waitrequest", idx), 64'(s1_waitrequest), 64'(!v.en));
        chk($sformatf("vec%0d_s2_waitrequest", idx), 64'(s2_waitrequest), 64'(!v.en));
        if (!s1_waitrequest && v.r1 && !v.w1) q1.push_back('{v.e1, ecnt + LAT});
        if (!s2_waitrequest && v.r2 && !v.w2) q2.push_back('{v.e2, ecnt + LAT});
    endtask

    // Called at a negedge with reset high; releases reset and counts the clear window.
    task automatic wait_clear(input string tag);
        int busy_cnt;
        bit wt_ok;
        busy_cnt = 0;
        wt_ok = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!init_busy) break;
            busy_cnt++;
            wt_ok = wt_ok & s1_waitrequest & s2_waitrequest;
            @(negedge clk);
        end
        chk({tag, "_init_busy_cycles"}, 64'(busy_cnt), 64'(DEPTH));
        chk({tag, "_waitrequest_during_clear"}, 64'(wt_ok), 64'(1));
        chk({tag, "_waitrequest_after_clear"}, 64'({s1_waitrequest, s2_waitrequest}), 64'(0));
    endtask

    initial begin
        int p_before;

        // Columns: s1 {rd, wr, addr, be, wdata, expected}, s2 {same}, clken
        tbl.push_back(mk(1, 0,  5, 4'h0, 32'h0,        32'h0,        1, 0, 15, 4'h0, 32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 1,  5, 4'h5, 32'hDEADBEEF, 32'h0,        0, 0,  0, 4'h0, 32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 0,  5, 4'h0, 32'h0,        32'h00AD00EF, 1, 0,  0, 4'h0, 32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 1,  7, 4'hC, 32'h11111111, 32'h0,        0, 1,  7, 4'hF, 32'h22222222, 32'h0,        1));
        tbl.push_back(mk(1, 0,  7, 4'h0, 32'h0,        32'h11112222, 1, 0,  5, 4'h0, 32'h0,        32'h00AD00EF, 1));
        tbl.push_back(mk(0, 1,  3, 4'hF, 32'hA5A5A5A5, 32'h0,        1, 0,  3, 4'h0, 32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 0, 15, 4'h0, 32'h0,        32'h0,        1, 0,  3, 4'h0, 32'h0,        32'hA5A5A5A5, 1));
        tbl.push_back(mk(0, 1,  3, 4'h0, 32'hFFFFFFFF, 32'h0,        1, 0, 16, 4'h0, 32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 0,  3, 4'h0, 32'h0,        32'hA5A5A5A5, 0, 1, 20, 4'hF, 32'h12345678, 32'h0,        1));
        tbl.push_back(mk(1, 1,  9, 4'hF, 32'h0BADF00D, 32'h0,        1, 0, 15, 4'h0, 32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 0,  9, 4'h0, 32'h0,        32'h0BADF00D, 1, 0, 20, 4'h0, 32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 0, 15, 4'h0, 32'h0,        32'h0,        0, 1, 15, 4'h3, 32'h0000CAFE, 32'h0,        1));
        tbl.push_back(mk(1, 0,  4, 4'h0, 32'h0,        32'h0,        1, 0, 15, 4'h0, 32'h0,        32'h0000CAFE, 1));
        tbl.push_back(mk(0, 1,  0, 4'hF, 32'h00000100, 32'h0,        0, 1,  1, 4'hF, 32'h00000101, 32'h0,        1));
        tbl.push_back(mk(0, 1,  2, 4'hF, 32'h00000102, 32'h0,        0, 0,  0, 4'h0, 32'h0,        32'h0,        1));

        repeat (3) @(negedge clk);
        chk("reset_s1_readdatavalid", 64'(s1_readdatavalid), 64'(0));
        chk("reset_s2_readdatavalid", 64'(s2_readdatavalid), 64'(0));
        chk("reset_readdata", 64'({s1_readdata, s2_readdata}), 64'(0));
        chk("reset_waitrequest", 64'({s1_waitrequest, s2_waitrequest}), 64'(2'b11));
        chk("reset_init_busy", 64'(init_busy), 64'(1));
        wait_clear("first_clear");

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Back-to-back s2 reads with a two-cycle clock-enable stall mid-burst.
        p_before = pulses2;
        apply(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 4'h0, 32'h0, 32'h00000100, 1), 100);
        apply(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 4'h0, 32'h0, 32'h00000101, 1), 101);
        apply(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 2, 4'h0, 32'h0, 32'h00000102, 0), 102);
        apply(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 2, 4'h0, 32'h0, 32'h00000102, 0), 103);
        apply(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 2, 4'h0, 32'h0, 32'h00000102, 1), 104);
        apply(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 3, 4'h0, 32'h0, 32'hA5A5A5A5, 1), 105);
        apply(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1), 106);
        apply(mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1), 107);
        chk("stall_burst_s2_pulses", 64'(pulses2 - p_before), 64'(4));

        // Read in flight, then reset: pipeline must be flushed.
        apply(mk(1, 0, 2, 4'h0, 32'h0, 32'h00000102, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1), 108);
        @(negedge clk);
        #2;
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        chk("flush_readdatavalid", 64'({s1_readdatavalid, s2_readdatavalid}), 64'(0));
        chk("flush_readdata", 64'({s1_readdata, s2_readdata}), 64'(0));
        chk("flush_init_busy", 64'(init_busy), 64'(1));
        #2;
        reset = 1'b0;

        // Interrupt the clear at count 9; the sequencer must restart from word 0.
        repeat (9) @(negedge clk);
        chk("mid_clear_init_busy", 64'(init_busy), 64'(1));
        #2;
        reset = 1'b1;
        @(negedge clk);
        wait_clear("restart_clear");

        apply(mk(1, 0,  5, 4'h0, 32'h0, 32'h0, 1, 0, DEPTH, 4'h0, 32'h0, 32'h0, 1), 200);
        apply(mk(1, 0,  7, 4'h0, 32'h0, 32'h0, 1, 0,     0, 4'h0, 32'h0, 32'h0, 1), 201);
        apply(mk(1, 0, 31, 4'h0, 32'h0, 32'h0, 1, 0,    15, 4'h0, 32'h0, 32'h0, 1), 202);
        apply(mk(0, 0,  0, 4'h0, 32'h0, 32'h0, 0, 0,     0, 4'h0, 32'h0, 32'h0, 1), 203);
        apply(mk(0, 0,  0, 4'h0, 32'h0, 32'h0, 0, 0,     0, 4'h0, 32'h0, 32'h0, 1), 204);
        @(negedge clk);
        chk("s1_scoreboard_drained", 64'(q1.size()), 64'(0));
        chk("s2_scoreboard_drained", 64'(q2.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
